// File: rtl/aes256_round_seq.sv
// AES-256 round sequencer: owns the cipher state register and steps one shared
// round datapath through NR rounds per block, encrypt or decrypt.
module aes256_round_seq #(
  parameter int unsigned NR  = 14,
  parameter int unsigned DW  = 128,
  parameter int unsigned RIW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_decrypt,
  input  logic [DW-1:0]  in_block,
  output logic [RIW-1:0] rk_idx,
  input  logic [DW-1:0]  rk,
  output logic [DW-1:0]  dp_state,
  output logic           dp_decrypt,
  output logic           dp_last,
  input  logic [DW-1:0]  dp_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_block,
  output logic           busy,
  output logic [RIW-1:0] round_cnt
);

  localparam logic [RIW-1:0] NR_C  = RIW'(NR);
  localparam logic [RIW-1:0] ONE_C = RIW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e         state_q;
  logic [DW-1:0]  blk_q;
  logic           mode_q;
  logic [RIW-1:0] cnt_q;
  logic [RIW-1:0] cnt_d;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic           dp_last_q;
  logic           dp_decrypt_q;

  assign cnt_d = cnt_q + ONE_C;

  // Sequencer FSM; every output except rk_idx is a flop updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      blk_q        <= '0;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      dp_last_q    <= 1'b0;
      dp_decrypt_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q      <= S_RUN;
            blk_q        <= in_block ^ rk;
            mode_q       <= in_decrypt;
            cnt_q        <= ONE_C;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            dp_decrypt_q <= in_decrypt;
            dp_last_q    <= (ONE_C == NR_C);
          end
        end
        S_RUN: begin
          blk_q <= dp_result;
          if (cnt_q == NR_C) begin
            state_q      <= S_DONE;
            cnt_q        <= '0;
            dp_last_q    <= 1'b0;
            dp_decrypt_q <= 1'b0;
            out_valid_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_d;
            dp_last_q <= (cnt_d == NR_C);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Key index: whitening key is selected from the offered mode while idle.
  always_comb begin
    rk_idx = '0;
    case (state_q)
      S_IDLE:  rk_idx = in_decrypt ? NR_C : '0;
      S_RUN:   rk_idx = mode_q ? (NR_C - cnt_q) : cnt_q;
      default: rk_idx = '0;
    endcase
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign dp_last    = dp_last_q;
  assign dp_decrypt = dp_decrypt_q;
  assign dp_state   = blk_q;
  assign out_block  = blk_q;
  assign round_cnt  = cnt_q;

endmodule

// File: tb/tb_aes256_round_seq.sv
// Bench for aes256_round_seq: supplies a reference key schedule and round datapath,
// and checks the sequencer every cycle against a cycle-count model plus full-cipher results.
module tb_aes256_round_seq;

  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk, rst_n, in_valid, in_ready, in_decrypt;
  logic [127:0] in_block, rk, dp_state, dp_result, out_block;
  logic [3:0]   rk_idx, round_cnt;
  logic         dp_decrypt, dp_last, out_valid, out_ready, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_en = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [31:0]  w [60];
  logic [127:0] rkeys [16];

  logic [127:0] out_q [$];
  int           outcyc_q [$];

  // model of the sequencer as seen from outside
  bit           m_busy = 0;
  int           m_age = 0;
  logic         m_mode = 0;
  logic [127:0] m_exp = '0;
  logic [127:0] m_last = '0;

  aes256_round_seq #(.NR(14), .DW(128), .RIW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_decrypt(in_decrypt), .in_block(in_block), .rk_idx(rk_idx), .rk(rk),
    .dp_state(dp_state), .dp_decrypt(dp_decrypt), .dp_last(dp_last),
    .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .busy(busy), .round_cnt(round_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] v, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv ? isbox[getb(v, i)] : sbox[getb(v, i)];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] v, input logic inv);
    logic [127:0] r;
    int src;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        src = inv ? (c - rr + 4) % 4 : (c + rr) % 4;
        r[127-8*(4*c+rr) -: 8] = getb(v, 4*src + rr);
      end
    return r;
  endfunction

  function automatic logic [7:0] coef(input logic inv, input int k);
    if (!inv) return (k == 0) ? 8'h02 : (k == 1) ? 8'h03 : 8'h01;
    case (k)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] v, input logic inv);
    logic [127:0] r;
    logic [7:0] acc;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef(inv, (k - rr + 4) % 4), getb(v, 4*c + k));
        r[127-8*(4*c+rr) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic dec, input logic last);
    logic [127:0] t;
    if (!dec) begin
      t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (!last) t = mix_columns(t, 1'b0);
      t = t ^ k;
    end else begin
      t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
      if (!last) t = mix_columns(t, 1'b1);
    end
    return t;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rkeys[0];
    for (int r = 1; r <= 14; r++) s = aes_round(s, rkeys[r], 1'b0, r == 14);
    return s;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] c);
    logic [127:0] s;
    s = c ^ rkeys[14];
    for (int r = 1; r <= 14; r++) s = aes_round(s, rkeys[14-r], 1'b1, r == 14);
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  // environment: key schedule lookup and the shared round datapath
  assign rk = rkeys[rk_idx];
  assign dp_result = aes_round(dp_state, rk, dp_decrypt, dp_last);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // reference model: idle, fourteen round cycles, then hold until taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_age  <= 0;
      m_last <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1;
        m_age  <= 0;
        m_mode <= in_decrypt;
        m_exp  <= in_decrypt ? aes_dec(in_block) : aes_enc(in_block);
      end
    end else if (m_age < 14) begin
      m_age <= m_age + 1;
    end else if (out_ready) begin
      m_busy <= 0;
      m_last <= m_exp;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!m_busy) begin
        chk("idle.in_ready", 128'(in_ready), 128'(1'b1));
        chk("idle.out_valid", 128'(out_valid), 128'(1'b0));
        chk("idle.busy", 128'(busy), 128'(1'b0));
        chk("idle.round_cnt", 128'(round_cnt), 128'(0));
        chk("idle.rk_idx", 128'(rk_idx), in_decrypt ? 128'(14) : 128'(0));
        chk("idle.out_block", out_block, m_last);
      end else if (m_age < 14) begin
        chk("run.in_ready", 128'(in_ready), 128'(1'b0));
        chk("run.out_valid", 128'(out_valid), 128'(1'b0));
        chk("run.busy", 128'(busy), 128'(1'b1));
        chk("run.round_cnt", 128'(round_cnt), 128'(m_age + 1));
        chk("run.rk_idx", 128'(rk_idx), m_mode ? 128'(13 - m_age) : 128'(m_age + 1));
        chk("run.dp_last", 128'(dp_last), 128'(m_age == 13));
        chk("run.dp_decrypt", 128'(dp_decrypt), 128'(m_mode));
      end else begin
        chk("done.out_valid", 128'(out_valid), 128'(1'b1));
        chk("done.in_ready", 128'(in_ready), 128'(1'b0));
        chk("done.busy", 128'(busy), 128'(1'b1));
        chk("done.round_cnt", 128'(round_cnt), 128'(0));
        chk("done.out_block", out_block, m_exp);
        chk("done.dp_state", dp_state, m_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && out_valid && out_ready) begin
      out_q.push_back(out_block);
      outcyc_q.push_back(cyc);
    end
  end

  task automatic send(input logic [127:0] blk, input logic dec, output int acc_cyc);
    int k;
    k = 0;
    @(posedge clk); #2;
    in_valid = 1'b1; in_block = blk; in_decrypt = dec;
    @(negedge clk);
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    chk("send.accept", 128'(in_ready), 128'(1'b1));
    acc_cyc = cyc;
    @(posedge clk); #2;
    in_valid = 1'b0; in_block = ~blk; in_decrypt = ~dec;
  endtask

  task automatic wait_outs(input int n, input string nm);
    int k;
    k = 0;
    while (out_q.size() < n && k < 200) begin @(negedge clk); k++; end
    chk(nm, 128'(out_q.size()), 128'(n));
  endtask

  task automatic wait_round(input int r);
    int k;
    k = 0;
    while (round_cnt != 4'(r) && k < 100) begin @(negedge clk); k++; end
    chk("wait_round", 128'(round_cnt), 128'(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no completion, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, k, base;
    logic [7:0] inv, x, s, rc;
    logic [31:0] t;

    rst_n = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; in_block = '0; out_ready = 1'b1;

    for (int i = 0; i < 256; i++) begin
      x = 8'(i); inv = 8'h00;
      for (int j = 1; j < 256; j++) if (x != 0 && gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[i] = s;
    end
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = KEY[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rkeys[15] = '0;

    chk("model.sbox00", 128'(sbox[0]), 128'(8'h63));
    chk("model.sbox53", 128'(sbox[8'h53]), 128'(8'hed));
    chk("model.enc_c3", aes_enc(PT), CT);
    chk("model.dec_c3", aes_dec(CT), PT);

    #1 rst_n = 1'b0;
    #2;
    chk("reset.in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset.out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset.busy", 128'(busy), 128'(1'b0));
    chk("reset.round_cnt", 128'(round_cnt), 128'(0));
    chk("reset.rk_idx", 128'(rk_idx), 128'(0));
    chk("reset.out_block", out_block, 128'(0));
    chk("reset.dp_last", 128'(dp_last), 128'(1'b0));
    chk("reset.dp_decrypt", 128'(dp_decrypt), 128'(1'b0));
    @(negedge clk); #1 rst_n = 1'b1;
    cmp_en = 1;

    // encrypt C.3 vector, sink always ready
    send(PT, 1'b0, acc);
    wait_outs(1, "enc.count");
    chk("enc.block", out_q[0], CT);
    chk("enc.latency", 128'(outcyc_q[0] - acc), 128'(15));

    // decrypt it back
    send(CT, 1'b1, acc);
    wait_outs(2, "dec.count");
    chk("dec.block", out_q[1], PT);

    // backpressure held for five cycles in DONE
    @(posedge clk); #2 out_ready = 1'b0;
    send(PT, 1'b0, acc);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", 128'(out_valid), 128'(1'b1));
      chk("bp.in_ready", 128'(in_ready), 128'(1'b0));
      chk("bp.out_block", out_block, CT);
      @(negedge clk);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(negedge clk);
    chk("bp.take_valid", 128'(out_valid), 128'(1'b1));
    @(negedge clk);
    chk("bp.after_in_ready", 128'(in_ready), 128'(1'b1));
    chk("bp.after_out_valid", 128'(out_valid), 128'(1'b0));
    wait_outs(3, "bp.count");
    chk("bp.block", out_q[2], CT);

    // offer a second block mid-run; it must be ignored
    send(PT, 1'b0, acc);
    wait_round(5);
    #1 in_valid = 1'b1; in_block = 128'hdeadbeef_01234567_89abcdef_cafef00d; in_decrypt = 1'b1;
    @(posedge clk); #2 in_valid = 1'b0;
    wait_outs(4, "ignore.count");
    chk("ignore.block", out_q[3], CT);
    repeat (20) @(negedge clk);
    chk("ignore.no_extra", 128'(out_q.size()), 128'(4));

    // asynchronous reset in round 7
    send(PT, 1'b0, acc);
    wait_round(7);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 128'(out_valid), 128'(1'b0));
    chk("arst.in_ready", 128'(in_ready), 128'(1'b1));
    chk("arst.round_cnt", 128'(round_cnt), 128'(0));
    chk("arst.busy", 128'(busy), 128'(1'b0));
    chk("arst.out_block", out_block, 128'(0));
    @(negedge clk); #1 rst_n = 1'b1;
    send(PT, 1'b0, acc);
    wait_outs(5, "arst.count");
    chk("arst.block", out_q[4], CT);

    // back-to-back encrypt then decrypt with in_valid held
    base = out_q.size();
    @(posedge clk); #2 in_valid = 1'b1; in_block = PT; in_decrypt = 1'b0;
    @(negedge clk);
    chk("b2b.first_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #2 in_block = CT; in_decrypt = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #2 in_valid = 1'b0;
    wait_outs(base + 2, "b2b.count");
    chk("b2b.enc", out_q[base], CT);
    chk("b2b.dec", out_q[base+1], PT);
    chk("b2b.spacing", 128'(outcyc_q[base+1] - outcyc_q[base]), 128'(16));

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
